// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with three combinational read
// ports, two write ports (port 1 wins on collision), an auto-incrementing PC in
// the top register and a per-register busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports; left undefined, reads return stored values only.
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_INC = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic              BUSY_A,
  output logic              BUSY_B,
  output logic              BUSY_C,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              PC_EN,
  input  logic              LOCK,
  input  logic [ADDR_W-1:0] LA
);

  localparam int N = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] pcAddr = ADDR_W'(N - 1);
  localparam logic [DATA_W-1:0] pcStep = DATA_W'(PC_INC);

  logic [DATA_W-1:0] regs    [N];
  logic [DATA_W-1:0] regNext [N];
  logic [N-1:0]      busy;
  logic [N-1:0]      busyNext;

  // Read value for one port; bypass forwards write data (port 1 over port 0).
  // A PC advance without a write is never forwarded, so the old PC is read.
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (WE1 && (WA1 == addr)) begin
      val = WD1;
    end else if (WE0 && (WA0 == addr)) begin
      val = WD0;
    end
`endif
    return val;
  endfunction

  // Next-state: PC advance first, then writes (port 1 last so it wins),
  // then LOCK so a lock beats a write-clear on the same register.
  always_comb begin
    regNext  = regs;
    busyNext = busy;
    if (PC_EN) begin
      regNext[pcAddr] = regs[pcAddr] + pcStep;
    end
    if (WE0) begin
      regNext[WA0]  = WD0;
      busyNext[WA0] = 1'b0;
    end
    if (WE1) begin
      regNext[WA1]  = WD1;
      busyNext[WA1] = 1'b0;
    end
    if (LOCK) begin
      busyNext[LA] = 1'b1;
    end
  end

  // Register and scoreboard state; CLR clears everything without waiting for CLK.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= regNext[i];
      end
      busy <= busyNext;
    end
  end

  // Read ports; forced to zero while in reset so bypassed data cannot leak out.
  always_comb begin
    A      = CLR ? readPort(RA) : '0;
    B      = CLR ? readPort(RB) : '0;
    C      = CLR ? readPort(RC) : '0;
    BUSY_A = CLR & busy[RA];
    BUSY_B = CLR & busy[RB];
    BUSY_C = CLR & busy[RC];
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios followed by
// randomized traffic checked against an array-based reference model.
module tb_register_file_mp;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [3:0]  RA, RB, RC, WA0, WA1, LA;
  logic [31:0] A, B, C, WD0, WD1;
  logic        BUSY_A, BUSY_B, BUSY_C;
  logic        WE0, WE1, PC_EN, LOCK;

  int checks = 0;
  int errors = 0;

  // reference model: register contents and busy flags
  logic [31:0] mReg  [16];
  logic        mBusy [16];

  register_file_mp #(.DATA_W(32), .ADDR_W(4), .PC_INC(4)) dut (
    .CLK(CLK), .CLR(CLR),
    .RA(RA), .RB(RB), .RC(RC),
    .A(A), .B(B), .C(C),
    .BUSY_A(BUSY_A), .BUSY_B(BUSY_B), .BUSY_C(BUSY_C),
    .WE0(WE0), .WA0(WA0), .WD0(WD0),
    .WE1(WE1), .WA1(WA1), .WD1(WD1),
    .PC_EN(PC_EN), .LOCK(LOCK), .LA(LA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      mReg[i]  = 32'h0;
      mBusy[i] = 1'b0;
    end
  endfunction

  // What one clock edge does under the stated rules.
  function automatic void modelEdge();
    logic pcWritten;
    if (!CLR) return;
    pcWritten = (WE0 && WA0 == 4'd15) || (WE1 && WA1 == 4'd15);
    if (PC_EN && !pcWritten) mReg[15] = mReg[15] + 32'd4;
    if (WE0) begin mReg[WA0] = WD0; mBusy[WA0] = 1'b0; end
    if (WE1) begin mReg[WA1] = WD1; mBusy[WA1] = 1'b0; end
    if (LOCK) mBusy[LA] = 1'b1;
  endfunction

  function automatic logic [31:0] expRead(input logic [3:0] addr);
    if (!CLR) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (WE1 && WA1 == addr) return WD1;
    if (WE0 && WA0 == addr) return WD0;
`endif
    return mReg[addr];
  endfunction

  task automatic idle();
    WE0 = 0; WE1 = 0; PC_EN = 0; LOCK = 0;
  endtask

  // Advance one cycle; returns at negedge+1 with the model updated.
  task automatic step();
    modelEdge();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 0; idle();
    RA = 0; RB = 7; RC = 15; WA0 = 7; WA1 = 0; LA = 7; WD0 = 32'hA5A5A5A5; WD1 = 0;
    modelReset();
    @(negedge CLK); #1;
    WE0 = 1; LOCK = 1; PC_EN = 1;
    @(posedge CLK); @(negedge CLK); #1;
    checks++; if (B !== 32'h0) begin errors++; $display("FAIL reset_write_ignored B=%h exp=%h", B, 32'h0); end
    idle();
    CLR = 1; #1;
    checks++; if (A !== 32'h0) begin errors++; $display("FAIL reset_A got=%h exp=%h", A, 32'h0); end
    checks++; if (B !== 32'h0) begin errors++; $display("FAIL reset_B got=%h exp=%h", B, 32'h0); end
    checks++; if (C !== 32'h0) begin errors++; $display("FAIL reset_C got=%h exp=%h", C, 32'h0); end
    checks++; if ({BUSY_A, BUSY_B, BUSY_C} !== 3'b000)
      begin errors++; $display("FAIL reset_busy got=%b exp=000", {BUSY_A, BUSY_B, BUSY_C}); end
  endtask

  task automatic test_dual_write();
    idle();
    WE0 = 1; WA0 = 3; WD0 = 32'h11111111;
    WE1 = 1; WA1 = 3; WD1 = 32'h22222222;
    step();
    idle(); RA = 3; #1;
    checks++; if (A !== 32'h22222222) begin errors++; $display("FAIL collision_R3 got=%h exp=%h", A, 32'h22222222); end
  endtask

  task automatic test_pc();
    idle(); RA = 15;
    WE0 = 1; WA0 = 15; WD0 = 32'hFFFFFFFC;
    step();
    idle(); #1;
    checks++; if (A !== 32'hFFFFFFFC) begin errors++; $display("FAIL pc_load got=%h exp=%h", A, 32'hFFFFFFFC); end
    PC_EN = 1;
    step();
    idle(); #1;
    checks++; if (A !== 32'h0) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", A, 32'h0); end
    PC_EN = 1; WE0 = 1; WA0 = 15; WD0 = 32'h100;
    step();
    idle(); #1;
    checks++; if (A !== 32'h100) begin errors++; $display("FAIL pc_write_priority got=%h exp=%h", A, 32'h100); end
    PC_EN = 1; #1;
    checks++; if (A !== 32'h100) begin errors++; $display("FAIL pc_old_before_edge got=%h exp=%h", A, 32'h100); end
    step();
    idle(); #1;
    checks++; if (A !== 32'h104) begin errors++; $display("FAIL pc_increment got=%h exp=%h", A, 32'h104); end
  endtask

  task automatic test_scoreboard();
    idle(); RA = 5;
    LOCK = 1; LA = 5; #1;
    checks++; if (BUSY_A !== 1'b0) begin errors++; $display("FAIL lock_no_forward got=%b exp=0", BUSY_A); end
    step();
    idle(); #1;
    checks++; if (BUSY_A !== 1'b1) begin errors++; $display("FAIL lock_set got=%b exp=1", BUSY_A); end
    WE1 = 1; WA1 = 5; WD1 = 32'h55;
    step();
    idle(); #1;
    checks++; if (BUSY_A !== 1'b0) begin errors++; $display("FAIL write_clears_busy got=%b exp=0", BUSY_A); end
    checks++; if (A !== 32'h55) begin errors++; $display("FAIL write_R5 got=%h exp=%h", A, 32'h55); end
    LOCK = 1; LA = 5; WE0 = 1; WA0 = 5; WD0 = 32'hAB;
    step();
    idle(); #1;
    checks++; if (BUSY_A !== 1'b1) begin errors++; $display("FAIL lock_beats_write got=%b exp=1", BUSY_A); end
    checks++; if (A !== 32'hAB) begin errors++; $display("FAIL lock_write_data got=%h exp=%h", A, 32'hAB); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    idle(); RA = 9;
    WE0 = 1; WA0 = 9; WD0 = 32'hDEADBEEF; #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hDEADBEEF;
`else
    exp = 32'h0;
`endif
    checks++; if (A !== exp) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", A, exp); end
    step();
    idle(); #1;
    checks++; if (A !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_after_edge got=%h exp=%h", A, 32'hDEADBEEF); end
    WE0 = 1; WA0 = 9; WD0 = 32'h0000AAAA;
    WE1 = 1; WA1 = 9; WD1 = 32'h0000BBBB; #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'h0000BBBB;
`else
    exp = 32'hDEADBEEF;
`endif
    checks++; if (A !== exp) begin errors++; $display("FAIL bypass_port1_wins got=%h exp=%h", A, exp); end
    step();
    idle(); #1;
  endtask

  task automatic test_async_reset();
    idle(); RA = 2;
    WE0 = 1; WA0 = 2; WD0 = 32'h1234;
    step();
    idle(); #1;
    checks++; if (A !== 32'h1234) begin errors++; $display("FAIL pre_reset_R2 got=%h exp=%h", A, 32'h1234); end
    WE0 = 1; WA0 = 2; WD0 = 32'h5555; LOCK = 1; LA = 2;
    #1 CLR = 0;
    #1;
    checks++; if (A !== 32'h0) begin errors++; $display("FAIL async_clear got=%h exp=%h", A, 32'h0); end
    @(posedge CLK); #1;
    checks++; if (A !== 32'h0 || BUSY_A !== 1'b0)
      begin errors++; $display("FAIL write_during_reset A=%h busy=%b exp=0/0", A, BUSY_A); end
    @(negedge CLK);
    idle();
    #1 CLR = 1;
    modelReset();
    #1;
    checks++; if (A !== 32'h0) begin errors++; $display("FAIL write_not_landed got=%h exp=%h", A, 32'h0); end
    WE1 = 1; WA1 = 2; WD1 = 32'h77;
    step();
    idle(); #1;
    checks++; if (A !== 32'h77) begin errors++; $display("FAIL first_edge_after_reset got=%h exp=%h", A, 32'h77); end
  endtask

  task automatic test_random();
    logic [31:0] eA, eB, eC;
    for (int n = 0; n < 400; n++) begin
      RA = 4'($urandom); RB = 4'($urandom); RC = 4'($urandom);
      WE0 = ($urandom_range(0, 2) == 0); WA0 = 4'($urandom); WD0 = $urandom;
      WE1 = ($urandom_range(0, 2) == 0); WA1 = 4'($urandom); WD1 = $urandom;
      if ($urandom_range(0, 3) == 0) WA1 = WA0;
      PC_EN = ($urandom_range(0, 1) == 0);
      LOCK  = ($urandom_range(0, 2) == 0); LA = 4'($urandom);
      if ($urandom_range(0, 5) == 0) RA = 4'd15;
      #1;
      eA = expRead(RA); eB = expRead(RB); eC = expRead(RC);
      checks++; if (A !== eA) begin errors++; $display("FAIL rand_A[%0d] RA=%0d got=%h exp=%h", n, RA, A, eA); end
      checks++; if (B !== eB) begin errors++; $display("FAIL rand_B[%0d] RB=%0d got=%h exp=%h", n, RB, B, eB); end
      checks++; if (C !== eC) begin errors++; $display("FAIL rand_C[%0d] RC=%0d got=%h exp=%h", n, RC, C, eC); end
      checks++; if (BUSY_A !== mBusy[RA]) begin errors++; $display("FAIL rand_BUSY_A[%0d] got=%b exp=%b", n, BUSY_A, mBusy[RA]); end
      checks++; if (BUSY_B !== mBusy[RB]) begin errors++; $display("FAIL rand_BUSY_B[%0d] got=%b exp=%b", n, BUSY_B, mBusy[RB]); end
      checks++; if (BUSY_C !== mBusy[RC]) begin errors++; $display("FAIL rand_BUSY_C[%0d] got=%b exp=%b", n, BUSY_C, mBusy[RC]); end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_pc();
    test_scoreboard();
    test_bypass();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 4: address width; depth N = 2**ADDR_W; register N-1 is the PC.
REQ-003 The module SHALL have parameter PC_INC, default 4: PC auto-increment step.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port CLR, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have ports RA, RB, RC, input, ADDR_W bits each: the three read addresses.
REQ-007 The module SHALL have ports A, B, C, output, DATA_W bits each: the combinational read data for RA, RB and RC.
REQ-008 The module SHALL have ports BUSY_A, BUSY_B, BUSY_C, output, 1 bit each: the scoreboard busy bit of RA, RB and RC.
REQ-009 The module SHALL have write port 0 as WE0 (input, 1 bit), WA0 (input, ADDR_W bits) and WD0 (input, DATA_W bits).
REQ-010 The module SHALL have write port 1 as WE1 (input, 1 bit), WA1 (input, ADDR_W bits) and WD1 (input, DATA_W bits).
REQ-011 The module SHALL have port PC_EN, input, 1 bit: advance the PC by PC_INC on the next edge.
REQ-012 The module SHALL have ports LOCK (input, 1 bit) and LA (input, ADDR_W bits): on the next edge, mark register LA busy.

Function
REQ-013 A read with RA, RB or RC SHALL return the stored register value combinationally, with zero latency.
REQ-014 WE0=1 SHALL load WD0 into register WA0 on the rising edge; WE1/WA1/WD1 SHALL behave the same way.
REQ-015 When WE0=WE1=1 and WA0==WA1, port 1 SHALL win and WD1 SHALL be stored.
REQ-016 PC_EN=1 with no write to N-1 SHALL set PC to PC+PC_INC, modulo 2**DATA_W (wraps silently).
REQ-017 A write to N-1 in the same cycle as PC_EN=1 SHALL take priority, and the PC SHALL take the write data with no increment.
REQ-018 A write on either port SHALL clear the busy bit of its target register.
REQ-019 LOCK=1 SHALL set busy[LA].
REQ-020 When LOCK and a write target the same address in the same cycle, the lock SHALL win, and busy SHALL stay set while the data is still stored.
REQ-021 BUSY_x SHALL equal busy[Rx] as registered, with no same-cycle forwarding of LOCK or write.
REQ-022 Registers not written and not the PC-advanced register SHALL hold their value.

Reset
REQ-023 CLR=0 SHALL immediately, independent of CLK, clear all N registers to 0 and all busy bits to 0.
REQ-024 While CLR=0, writes, LOCK and PC_EN SHALL be ignored, and A/B/C SHALL read 0 and BUSY_* SHALL read 0.
REQ-025 When reset is asserted mid-operation, pending writes in that cycle SHALL be discarded; the first edge after CLR rises SHALL operate normally.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, a read whose address matches an active write port in the same cycle SHALL return that write data (port 1 over port 0), and a read of N-1 with PC_EN and no write SHALL still return the old PC.
REQ-027 With REGFILE_BYPASS_EN undefined, all reads SHALL return stored values only, so a written value is visible in the cycle after the edge.

Verification
REQ-028 The bench SHALL cover reset then read: CLR=0, then 1; RA=0, RB=7, RC=15 -> A=B=C=0 and BUSY_*=0.
REQ-029 The bench SHALL cover dual write with collision: WE0=WE1=1, WA0=WA1=3, WD0=0x11111111, WD1=0x22222222 -> R3=0x22222222 after the edge.
REQ-030 The bench SHALL cover PC increment and wrap: write R15=0xFFFFFFFC, then PC_EN for one cycle -> R15=0x00000000; PC_EN together with WE0 to R15 carrying 0x100 -> R15=0x100.
REQ-031 The bench SHALL cover the scoreboard: LOCK, LA=5 -> BUSY_A=1 with RA=5; WE1 to R5 -> BUSY_A=0 next cycle; LOCK and WE0 both at R5 in one cycle -> BUSY_A=1 and R5 updated.
REQ-032 The bench SHALL cover bypass: WE0 to R9 with 0xDEADBEEF and RA=9 in the same cycle -> A=0xDEADBEEF before the edge with REGFILE_BYPASS_EN defined, and the old value without it.
REQ-033 The bench SHALL cover async reset mid-write: CLR=0 pulsed between edges while WE0 is asserted to R2 -> R2=0 immediately, and the write does not land.
